// File: rtl/stepper_microstep_writer_pkg.sv
// stepper_pkg: shared types and helpers for the stepper microstep writer.
//   state_t       - writer FSM states
//   FLAG_REG_ADDR - address of the PWM block's mode-flag register
//   PHASE_BITS    - width of a motor's microstep phase (64 steps per cycle)
//   SINE_T        - first quarter of a 127-amplitude sine, 17 points
//   pack_coil     - packs two sign/magnitude values into a coil word
//   sine_sm       - sign/magnitude sine of a phase
package stepper_pkg;

    typedef enum logic [2:0] {
        INIT_FLAGS, INIT_WORDS, IDLE, STEP, LOOKUP, WR_A, WR_B, WAIT
    } state_t;

    localparam logic [15:0] FLAG_REG_ADDR = 16'h00ff;
    localparam int          PHASE_BITS    = 6;
    localparam logic [15:0] PHASE0_WORD   = 16'h80ff;

    localparam logic [6:0] SINE_T [17] = '{
        7'd0, 7'd12, 7'd25, 7'd37, 7'd49, 7'd60, 7'd71, 7'd81, 7'd90,
        7'd98, 7'd106, 7'd112, 7'd117, 7'd122, 7'd125, 7'd126, 7'd127
    };

    function automatic logic [15:0] pack_coil(input logic sa, input logic [6:0] ma,
                                              input logic sb, input logic [6:0] mb);
        return {sa, ma, sb, mb};
    endfunction

    // Odd quarters read the table backwards; the upper half is negative,
    // except that a zero magnitude always reports a non-negative sign.
    function automatic logic [7:0] sine_sm(input logic [PHASE_BITS-1:0] p);
        logic [4:0] i;
        logic [6:0] m;
        i = p[4] ? 5'd16 - {1'b0, p[3:0]} : {1'b0, p[3:0]};
        m = SINE_T[i];
        return {!p[5] || m == 7'd0, m};
    endfunction

endpackage

// File: rtl/stepper_microstep_writer_sine_rom.sv
// microstep_sine_rom: registered sine/cosine coil-word lookup, 1-cycle latency.
//   clk, rst - clock, asynchronous active-high reset
//   i_phase  - microstep phase
//   o_coil   - {signA, |A|, signB, |B|} for A = sin(phase), B = cos(phase)
module microstep_sine_rom
    import stepper_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PHASE_BITS-1:0] i_phase,
    output logic [15:0]           o_coil
);

    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [15:0] r_coil;

    assign w_a = sine_sm(i_phase);
    assign w_b = sine_sm(i_phase + PHASE_BITS'(16));
    assign o_coil = r_coil;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_coil <= '0;
        else     r_coil <= pack_coil(w_a[7], w_a[6:0], w_b[7], w_b[6:0]);
    end

endmodule

// File: rtl/stepper_microstep_writer.sv
// stepper_microstep_writer: sole register writer of the stepper PWM block.
//   clk, rst               - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    - move command handshake
//   cmd_motor/dir/count/period - target motor, direction, microsteps, cycles per microstep
//   halt                   - end the active move after the current word pair
//   we, regIndex, regData  - PWM register write port
//   busy                   - FSM not in IDLE
//   done                   - 1-cycle pulse when a move ends
module stepper_microstep_writer
    import stepper_pkg::*;
#(
    parameter int          MOTORS     = 16,
    parameter logic [15:0] FLAGS_INIT = 16'h0001,
    parameter bit          DUAL       = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(MOTORS)-1:0] cmd_motor,
    input  logic                      cmd_dir,
    input  logic [7:0]                cmd_count,
    input  logic [15:0]               cmd_period,
    input  logic                      halt,
    output logic                      we,
    output logic [15:0]               regIndex,
    output logic [15:0]               regData,
    output logic                      busy,
    output logic                      done
);

    localparam int MB = $clog2(MOTORS);
    localparam int IB = $clog2(2 * MOTORS);

    state_t                r_state;
    state_t                w_next;
    logic [MB-1:0]         r_motor;
    logic                  r_dir;
    logic                  r_halt;
    logic                  r_done;
    logic [7:0]            r_count;
    logic [15:0]           r_per;
    logic [15:0]           r_wait;
    logic [IB-1:0]         r_idx;
    logic [PHASE_BITS-1:0] r_phase [MOTORS];
    logic [15:0]           w_coil;
    logic [15:0]           w_index;
    logic [15:0]           w_data;
    logic [15:0]           w_wait_n;
    logic                  w_we;
    logic                  w_done;
    logic                  w_stop;

    // r_per is already clamped to the 4-cycle pair minimum. The last pair
    // waits two extra cycles so done lands where the next WR_A would be.
    assign w_wait_n = (r_count == 8'd1) ? r_per - 16'd2 : r_per - 16'd4;
    assign w_stop   = halt | r_halt;

    // Outputs are decoded from state; rst masks them so the reset state
    // (INIT_FLAGS) does not already show its write.
    assign we       = w_we & ~rst;
    assign regIndex = rst ? 16'h0000 : w_index;
    assign regData  = rst ? 16'h0000 : w_data;
    assign busy     = r_state != IDLE;
    assign done     = r_done;

    microstep_sine_rom u_rom (
        .clk     (clk),
        .rst     (rst),
        .i_phase (r_phase[r_motor]),
        .o_coil  (w_coil)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= INIT_FLAGS;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_we      = 1'b0;
        w_index   = 16'h0000;
        w_data    = 16'h0000;
        w_done    = 1'b0;
        cmd_ready = 1'b0;
        case (r_state)
            INIT_FLAGS: begin
                w_we    = 1'b1;
                w_index = FLAG_REG_ADDR;
                w_data  = FLAGS_INIT;
                w_next  = INIT_WORDS;
            end
            INIT_WORDS: begin
                w_we    = 1'b1;
                w_index = 16'(r_idx);
                w_data  = (r_idx[0] && !DUAL) ? 16'h0000 : PHASE0_WORD;
                w_next  = (r_idx == IB'(2 * MOTORS - 1)) ? IDLE : INIT_WORDS;
            end
            IDLE: begin
                cmd_ready = 1'b1;
                w_done    = cmd_valid && cmd_count == 8'd0;
                w_next    = (cmd_valid && cmd_count != 8'd0) ? STEP : IDLE;
            end
            STEP:   w_next = LOOKUP;
            LOOKUP: w_next = WR_A;
            WR_A: begin
                w_we    = 1'b1;
                w_index = 16'({r_motor, 1'b0});
                w_data  = w_coil;
                w_next  = WR_B;
            end
            WR_B: begin
                // A zero wait only happens on a non-final pair at the minimum rate.
                w_we    = 1'b1;
                w_index = 16'({r_motor, 1'b1});
                w_data  = DUAL ? w_coil : 16'h0000;
                w_next  = (w_wait_n != 16'd0) ? WAIT : (w_stop ? IDLE : STEP);
                w_done  = w_wait_n == 16'd0 && w_stop;
            end
            WAIT: begin
                w_done = w_stop || (r_wait == 16'd1 && r_count == 8'd0);
                w_next = w_done ? IDLE : (r_wait == 16'd1 ? STEP : WAIT);
            end
            default: w_next = INIT_FLAGS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_motor <= '0;
            r_dir   <= 1'b0;
            r_halt  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= 8'd0;
            r_per   <= 16'd4;
            r_wait  <= 16'd0;
            r_idx   <= '0;
            for (int k = 0; k < MOTORS; k++) r_phase[k] <= '0;
        end else begin
            r_done <= w_done;
            // A halt seen mid-move is held until the current pair finishes.
            r_halt <= (r_state inside {STEP, LOOKUP, WR_A, WR_B, WAIT}) &&
                      (w_next inside {STEP, LOOKUP, WR_A, WR_B, WAIT}) && w_stop;
            if (r_state == INIT_FLAGS) r_idx <= '0;
            if (r_state == INIT_WORDS) r_idx <= r_idx + 1'b1;
            if (cmd_valid && cmd_ready) begin
                r_motor <= cmd_motor;
                r_dir   <= cmd_dir;
                r_count <= cmd_count;
                r_per   <= (cmd_period < 16'd4) ? 16'd4 : cmd_period;
            end
            if (r_state == STEP)
                r_phase[r_motor] <= r_dir ? r_phase[r_motor] + 1'b1 : r_phase[r_motor] - 1'b1;
            if (r_state == WR_B) begin
                r_count <= r_count - 8'd1;
                r_wait  <= w_wait_n;
            end
            if (r_state == WAIT) r_wait <= r_wait - 16'd1;
        end
    end

endmodule

// File: tb/tb_stepper_microstep_writer.sv
// tb_stepper_microstep_writer: self-checking bench for stepper_microstep_writer.
module tb_stepper_microstep_writer;

    localparam real TWO_PI = 6.283185307179586;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_motor = 4'd0;
    logic        cmd_dir = 1'b0;
    logic [7:0]  cmd_count = 8'd0;
    logic [15:0] cmd_period = 16'd0;
    logic        halt = 1'b0;
    logic        we;
    logic [15:0] regIndex;
    logic [15:0] regData;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ph [16];
    logic [31:0] exp_q [$];
    int          wa_cyc [$];
    logic [15:0] last_a = 16'h0000;

    stepper_microstep_writer #(.MOTORS(16), .FLAGS_INIT(16'h0001), .DUAL(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_motor  (cmd_motor),
        .cmd_dir    (cmd_dir),
        .cmd_count  (cmd_count),
        .cmd_period (cmd_period),
        .halt       (halt),
        .we         (we),
        .regIndex   (regIndex),
        .regData    (regData),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Coil word straight from trigonometry: A = 127 sin, B = 127 cos, rounded.
    function automatic logic [15:0] coil(input int p);
        real sa, sb;
        int  ma, mb;
        sa = 127.0 * $sin(TWO_PI * p / 64.0);
        sb = 127.0 * $cos(TWO_PI * p / 64.0);
        ma = $rtoi((sa < 0.0 ? -sa : sa) + 0.5);
        mb = $rtoi((sb < 0.0 ? -sb : sb) + 0.5);
        return {(ma == 0 || sa > 0.0), 7'(ma), (mb == 0 || sb > 0.0), 7'(mb)};
    endfunction

    // Every write is checked against the model's queue, in order.
    always @(negedge clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h/%h, expected no write", regIndex, regData);
            end else begin
                chk("write", {regIndex, regData}, exp_q.pop_front());
            end
            if (regIndex < 16'd32 && !regIndex[0]) begin
                wa_cyc.push_back(cyc);
                last_a = regData;
            end
        end
    end

    task automatic wait_ready(input int budget);
        int k;
        k = 0;
        while (!cmd_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("ready_seen", 32'(cmd_ready), 1);
    endtask

    task automatic wait_done(input int budget, output int c);
        c = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                c = cyc;
                break;
            end
        end
        chk("done_seen", 32'(c >= 0), 1);
        if (c >= 0) begin
            @(negedge clk);
            chk("done_pulse_width", 32'(done), 0);
        end
    endtask

    task automatic do_init();
        int r;
        exp_q.push_back({16'h00ff, 16'h0001});
        for (int a = 0; a < 32; a++)
            exp_q.push_back({16'(a), (a % 2 == 1) ? 16'h0000 : coil(0)});
        for (int m = 0; m < 16; m++) ph[m] = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        r = cyc;
        @(negedge clk);
        wait_ready(100);
        chk("init_ready_cycle", 32'(cyc - r), 33);
        chk("init_writes_left", 32'(exp_q.size()), 0);
    endtask

    // Queues the expected pairs (fewer than count when a halt is planned),
    // then performs the handshake; c0 is the cycle the handshake completes in.
    task automatic issue(input int m, input bit d, input int n, input int p,
                         input int pairs, output int c0);
        for (int k = 0; k < pairs; k++) begin
            ph[m] = (ph[m] + (d ? 1 : 63)) % 64;
            exp_q.push_back({16'(2 * m), coil(ph[m])});
            exp_q.push_back({16'(2 * m + 1), 16'h0000});
        end
        @(negedge clk);
        wait_ready(200);
        cmd_valid  = 1'b1;
        cmd_motor  = 4'(m);
        cmd_dir    = d;
        cmd_count  = 8'(n);
        cmd_period = 16'(p);
        c0 = cyc;
        wa_cyc.delete();
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    function automatic int first_wa();
        return (wa_cyc.size() > 0) ? wa_cyc[0] : -1000;
    endfunction

    function automatic int last_wa();
        return (wa_cyc.size() > 0) ? wa_cyc[wa_cyc.size() - 1] : -1000;
    endfunction

    initial begin
        int c0, c, bad, k;
        #2;
        chk("rst_we", 32'(we), 0);
        chk("rst_regIndex", 32'(regIndex), 0);
        chk("rst_regData", 32'(regData), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_done", 32'(done), 0);
        chk("pin_coil0", 32'(coil(0)), 32'h80ff);
        chk("pin_coil1", 32'(coil(1)), 32'h8cfe);
        chk("pin_coil63", 32'(coil(63)), 32'h0cfe);
        chk("pin_coil8", 32'(coil(8)), 32'hdada);
        chk("pin_coil32", 32'(coil(32)), 32'h807f);
        chk("pin_coil40", 32'(coil(40)), 32'h5a5a);
        #20;
        do_init();

        issue(3, 1'b1, 1, 10, 1, c0);
        wait_done(100, c);
        chk("m3_first_we_latency", 32'(first_wa() - c0), 3);
        chk("m3_done_after_wr_a", 32'(c - first_wa()), 10);
        chk("m3_word", 32'(last_a), 32'h8cfe);

        issue(0, 1'b0, 1, 0, 1, c0);
        wait_done(100, c);
        chk("m0_back_word", 32'(last_a), 32'h0cfe);
        chk("m0_done_min_period", 32'(c - first_wa()), 4);

        issue(0, 1'b1, 64, 0, 64, c0);
        wait_done(1000, c);
        bad = 0;
        for (int i = 1; i < wa_cyc.size(); i++) if (wa_cyc[i] - wa_cyc[i-1] != 4) bad++;
        chk("wrap_pairs", 32'(wa_cyc.size()), 64);
        chk("wrap_spacing", 32'(bad), 0);
        chk("wrap_word", 32'(last_a), 32'h0cfe);
        chk("wrap_done", 32'(c - last_wa()), 4);

        issue(1, 1'b1, 0, 9, 0, c0);
        wait_done(20, c);
        chk("zero_count_done", 32'(c - c0), 1);
        chk("zero_count_ready", 32'(cmd_ready), 1);

        issue(2, 1'b1, 3, 6, 3, c0);
        wait_done(200, c);
        bad = 0;
        for (int i = 1; i < wa_cyc.size(); i++) if (wa_cyc[i] - wa_cyc[i-1] != 6) bad++;
        chk("p6_pairs", 32'(wa_cyc.size()), 3);
        chk("p6_spacing", 32'(bad), 0);
        chk("p6_done", 32'(c - last_wa()), 6);

        issue(7, 1'b1, 20, 8, 5, c0);
        k = 0;
        while (wa_cyc.size() < 5 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("halt_reached_pair5", 32'(wa_cyc.size()), 5);
        if (wa_cyc.size() >= 5) begin
            while (cyc < wa_cyc[4] + 3) @(negedge clk);
            halt = 1'b1;
            @(posedge clk);
            #1 halt = 1'b0;
            wait_done(50, c);
            chk("halt_done", 32'(c - wa_cyc[4]), 4);
            chk("halt_pairs", 32'(wa_cyc.size()), 5);
        end
        issue(7, 1'b1, 1, 0, 1, c0);
        wait_done(50, c);
        chk("halt_resume_word", 32'(last_a), 32'hc7ea);

        issue(5, 1'b1, 10, 4, 10, c0);
        k = 0;
        while (!(we && regIndex == 16'd10) && k < 100) begin
            @(negedge clk);
            k++;
        end
        #1 rst = 1'b1;
        #1;
        chk("midrst_we", 32'(we), 0);
        chk("midrst_busy", 32'(busy), 1);
        chk("midrst_ready", 32'(cmd_ready), 0);
        exp_q.delete();
        @(negedge clk);
        do_init();
        issue(3, 1'b1, 1, 4, 1, c0);
        wait_done(50, c);
        chk("midrst_phase_reset", 32'(last_a), 32'h8cfe);

        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
